// File: rtl/nn_pkg.sv
// Shared definitions for the dense-layer datapath: fixed-point format, sequencer states
// and a counter-width helper.
package nn_pkg;

  localparam int unsigned N = 16;
  localparam int unsigned Q = 13;

  localparam logic [15:0] ONE_Q13 = 16'h2000;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    FIRE  = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } seq_state_t;

  // Width of a counter covering 0..range-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/layer_io_sequencer.sv
// Serial-to-parallel front end for one dense layer: gathers input words, fires the layer,
// waits for done (with timeout) and streams the captured outputs back out.
module layer_io_sequencer #(
  parameter int unsigned N              = 16,
  parameter int unsigned NUM_OF_INPUTS  = 4,
  parameter int unsigned NUM_OF_OUTPUTS = 2,
  parameter int unsigned TIMEOUT        = 64
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [N-1:0] layer_in [0:NUM_OF_INPUTS-1],
  output logic         fire,
  input  logic [N-1:0] layer_out [0:NUM_OF_OUTPUTS-1],
  input  logic         done,
  output logic [N-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         busy,
  output logic         timeout_err
);
  import nn_pkg::*;

  localparam int unsigned InW   = cnt_width(NUM_OF_INPUTS);
  localparam int unsigned OutW  = cnt_width(NUM_OF_OUTPUTS);
  localparam int unsigned WaitW = cnt_width(TIMEOUT);

  localparam logic [InW-1:0]   InLast   = InW'(NUM_OF_INPUTS - 1);
  localparam logic [OutW-1:0]  OutLast  = OutW'(NUM_OF_OUTPUTS - 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

  seq_state_t       state_q, state_d;
  logic [InW-1:0]   in_idx_q, in_idx_d;
  logic [OutW-1:0]  out_idx_q, out_idx_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic [N-1:0]     layer_in_q [0:NUM_OF_INPUTS-1];
  logic [N-1:0]     layer_in_d [0:NUM_OF_INPUTS-1];
  logic [N-1:0]     out_buf_q [0:NUM_OF_OUTPUTS-1];
  logic [N-1:0]     out_buf_d [0:NUM_OF_OUTPUTS-1];

  always_comb begin
    state_d       = state_q;
    in_idx_d      = in_idx_q;
    out_idx_d     = out_idx_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    layer_in_d    = layer_in_q;
    out_buf_d     = out_buf_q;
    unique case (state_q)
      LOAD: begin
        if (s_valid) begin
          layer_in_d[in_idx_q] = s_data;
          if (in_idx_q == InLast) begin
            in_idx_d = '0;
            state_d  = FIRE;
          end else begin
            in_idx_d = in_idx_q + InW'(1);
          end
        end
      end
      // done is deliberately not looked at here: a level left over from the last run
      // must not complete this one.
      FIRE: begin
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (done) begin
          out_buf_d = layer_out;
          out_idx_d = '0;
          state_d   = DRAIN;
        end else if (wait_cnt_q == WaitLast) begin
          timeout_err_d = 1'b1;
          state_d       = LOAD;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end
      DRAIN: begin
        if (m_ready) begin
          if (out_idx_q == OutLast) begin
            out_idx_d = '0;
            state_d   = LOAD;
          end else begin
            out_idx_d = out_idx_q + OutW'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= LOAD;
      in_idx_q      <= '0;
      out_idx_q     <= '0;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
      layer_in_q    <= '{default: '0};
      out_buf_q     <= '{default: '0};
    end else begin
      state_q       <= state_d;
      in_idx_q      <= in_idx_d;
      out_idx_q     <= out_idx_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
      layer_in_q    <= layer_in_d;
      out_buf_q     <= out_buf_d;
    end
  end

  assign s_ready     = (state_q == LOAD);
  assign fire        = (state_q == FIRE);
  assign m_valid     = (state_q == DRAIN);
  assign busy        = (state_q != LOAD);
  assign m_data      = m_valid ? out_buf_q[out_idx_q] : '0;
  assign timeout_err = timeout_err_q;
  assign layer_in    = layer_in_q;

endmodule

// File: tb/tb_layer_io_sequencer.sv
// Directed bench for layer_io_sequencer: a transaction-level model checked every cycle,
// plus hand-computed timing and data expectations for each scenario.
module tb_layer_io_sequencer;
  localparam int unsigned N  = 16;
  localparam int unsigned NI = 4;
  localparam int unsigned NO = 2;
  localparam int unsigned TO = 64;

  logic         clk = 1'b0;
  logic         rstn;
  logic [N-1:0] s_data;
  logic         s_valid;
  logic         s_ready;
  logic [N-1:0] layer_in [0:NI-1];
  logic         fire;
  logic [N-1:0] layer_out [0:NO-1];
  logic         done;
  logic [N-1:0] m_data;
  logic         m_valid;
  logic         m_ready;
  logic         busy;
  logic         timeout_err;

  always #5 clk = ~clk;

  layer_io_sequencer #(
    .N(N), .NUM_OF_INPUTS(NI), .NUM_OF_OUTPUTS(NO), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rstn(rstn), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .layer_in(layer_in), .fire(fire), .layer_out(layer_out), .done(done),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy),
    .timeout_err(timeout_err)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: words collected so far, a pending fire, cycles spent waiting (-1 = not
  // waiting), queue of words still to be emitted, sticky timeout.
  logic [N-1:0] mdl_in [0:NI-1];
  int           mdl_cnt;
  bit           mdl_fire;
  int           mdl_wait;
  logic [N-1:0] mdl_q [$];
  bit           mdl_terr;

  int           acc_cyc [$];
  int           fire_cyc [$];
  logic [N-1:0] emit_dat [$];
  int           emit_cyc [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) mdl_in[i] = '0;
    mdl_cnt  = 0;
    mdl_fire = 0;
    mdl_wait = -1;
    mdl_q.delete();
    mdl_terr = 0;
  endtask

  initial begin : compare
    bit e_busy;
    model_reset();
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) model_reset();
      e_busy = mdl_fire || (mdl_wait >= 0) || (mdl_q.size() > 0);
      chk("s_ready", {31'd0, s_ready}, {31'd0, !e_busy});
      chk("busy", {31'd0, busy}, {31'd0, e_busy});
      chk("fire", {31'd0, fire}, {31'd0, mdl_fire});
      chk("m_valid", {31'd0, m_valid}, {31'd0, mdl_q.size() > 0});
      chk("timeout_err", {31'd0, timeout_err}, {31'd0, mdl_terr});
      if (mdl_q.size() > 0) chk("m_data", {16'd0, m_data}, {16'd0, mdl_q[0]});
      for (int i = 0; i < NI; i++)
        chk($sformatf("layer_in%0d", i), {16'd0, layer_in[i]}, {16'd0, mdl_in[i]});
      if (s_valid && s_ready) acc_cyc.push_back(cyc);
      if (fire) fire_cyc.push_back(cyc);
      if (m_valid && m_ready) begin
        emit_dat.push_back(m_data);
        emit_cyc.push_back(cyc);
      end
      if (rstn) begin
        if (mdl_q.size() > 0) begin
          if (m_ready) void'(mdl_q.pop_front());
        end else if (mdl_wait >= 0) begin
          if (done) begin
            for (int i = 0; i < NO; i++) mdl_q.push_back(layer_out[i]);
            mdl_wait = -1;
          end else if (mdl_wait == TO - 1) begin
            mdl_terr = 1;
            mdl_wait = -1;
          end else begin
            mdl_wait++;
          end
        end else if (mdl_fire) begin
          mdl_fire = 0;
          mdl_wait = 0;
        end else if (s_valid) begin
          mdl_in[mdl_cnt] = s_data;
          mdl_cnt++;
          if (mdl_cnt == NI) begin
            mdl_cnt  = 0;
            mdl_fire = 1;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_logs();
    acc_cyc.delete();
    fire_cyc.delete();
    emit_dat.delete();
    emit_cyc.delete();
  endtask

  task automatic send(input logic [N-1:0] w);
    int g;
    bit acc;
    g = 0;
    do begin
      s_valid = 1'b1;
      s_data  = w;
      acc     = s_ready;
      step();
      g++;
    end while (!acc && g < 50);
    s_valid = 1'b0;
    if (!acc) chk("send_bound", 32'd0, 32'd1);
  endtask

  task automatic send4(input logic [N-1:0] a, b, c, d);
    send(a); send(b); send(c); send(d);
  endtask

  task automatic wait_fire();
    int g;
    g = 0;
    while (!fire && g < 100) begin step(); g++; end
    if (!fire) chk("fire_bound", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (!s_ready && g < 200) begin step(); g++; end
    if (!s_ready) chk("idle_bound", 32'd0, 32'd1);
  endtask

  task automatic layer_done(input int lat, input logic [N-1:0] a, b);
    repeat (lat) step();
    done = 1'b1;
    layer_out[0] = a;
    layer_out[1] = b;
    step();
    done = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin : stim
    logic [N-1:0] w [0:NI-1];
    int n;
    int widx;
    bit acc;
    rstn = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    done = 1'b0;
    m_ready = 1'b0;
    layer_out[0] = '0;
    layer_out[1] = '0;
    #1;
    chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
    chk("rst_fire", {31'd0, fire}, 32'd0);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_data", {16'd0, m_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
    step(); step();
    rstn = 1'b1;
    step();

    // Basic run
    clr_logs();
    m_ready = 1'b1;
    send4(16'h2000, 16'h1000, 16'hE000, 16'h0000);
    wait_fire();
    chk("basic_li0", {16'd0, layer_in[0]}, 32'h2000);
    chk("basic_li1", {16'd0, layer_in[1]}, 32'h1000);
    chk("basic_li2", {16'd0, layer_in[2]}, 32'hE000);
    chk("basic_li3", {16'd0, layer_in[3]}, 32'h0000);
    layer_done(5, 16'h1234, 16'hABCD);
    wait_idle();
    chk("basic_nacc", acc_cyc.size(), 32'd4);
    chk("basic_b2b", acc_cyc[3], acc_cyc[0] + 3);
    chk("basic_nfire", fire_cyc.size(), 32'd1);
    chk("basic_fire_lat", fire_cyc[0], acc_cyc[3] + 1);
    chk("basic_nemit", emit_dat.size(), 32'd2);
    chk("basic_out0", {16'd0, emit_dat[0]}, 32'h1234);
    chk("basic_out1", {16'd0, emit_dat[1]}, 32'hABCD);
    chk("basic_out_lat", emit_cyc[0], fire_cyc[0] + 6);
    chk("basic_out_b2b", emit_cyc[1], emit_cyc[0] + 1);

    // Backpressure
    clr_logs();
    m_ready = 1'b0;
    send4(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    wait_fire();
    layer_done(2, 16'h1234, 16'hABCD);
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", {31'd0, m_valid}, 32'd1);
      chk("bp_data", {16'd0, m_data}, 32'h1234);
      step();
    end
    m_ready = 1'b1;
    wait_idle();
    chk("bp_nemit", emit_dat.size(), 32'd2);
    chk("bp_out0", {16'd0, emit_dat[0]}, 32'h1234);
    chk("bp_out1", {16'd0, emit_dat[1]}, 32'hABCD);
    chk("bp_ready_after", acc_cyc.size(), 32'd4);

    // Stale done held high across FIRE
    clr_logs();
    done = 1'b1;
    layer_out[0] = 16'h5555;
    layer_out[1] = 16'hAAAA;
    send4(16'h0010, 16'h0020, 16'h0030, 16'h0040);
    wait_fire();
    wait_idle();
    done = 1'b0;
    chk("stale_nfire", fire_cyc.size(), 32'd1);
    chk("stale_lat", emit_cyc[0], fire_cyc[0] + 2);
    chk("stale_out0", {16'd0, emit_dat[0]}, 32'h5555);

    // Timeout, then a normal run
    clr_logs();
    send4(16'h0100, 16'h0200, 16'h0300, 16'h0400);
    wait_fire();
    n = 0;
    while (!s_ready && n < 200) begin step(); n++; end
    chk("to_cycles", n, 32'd65);
    chk("to_flag", {31'd0, timeout_err}, 32'd1);
    chk("to_no_emit", emit_dat.size(), 32'd0);
    send4(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D);
    wait_fire();
    layer_done(1, 16'h0F0F, 16'hF0F0);
    wait_idle();
    chk("to_rerun_out1", {16'd0, emit_dat[1]}, 32'hF0F0);
    chk("to_sticky", {31'd0, timeout_err}, 32'd1);

    // Reset in the middle of WAIT
    clr_logs();
    send4(16'h7777, 16'h6666, 16'h5555, 16'h4444);
    wait_fire();
    step(); step();
    rstn = 1'b0;
    #1;
    chk("mr_s_ready", {31'd0, s_ready}, 32'd1);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_m_valid", {31'd0, m_valid}, 32'd0);
    chk("mr_timeout", {31'd0, timeout_err}, 32'd0);
    for (int i = 0; i < NI; i++) chk("mr_layer_in", {16'd0, layer_in[i]}, 32'd0);
    step();
    rstn = 1'b1;
    layer_done(1, 16'h9999, 16'h8888);
    step(); step();
    chk("mr_done_ignored", {31'd0, m_valid}, 32'd0);
    chk("mr_idle", {31'd0, s_ready}, 32'd1);

    // Input gaps: s_valid toggles every cycle, including past FIRE
    clr_logs();
    w[0] = 16'h1111; w[1] = 16'h2222; w[2] = 16'h3333; w[3] = 16'h4444;
    widx = 0;
    n = 0;
    while (!fire && n < 40) begin
      s_valid = (n % 2 == 0);
      s_data  = (widx < NI) ? w[widx] : 16'hFFFF;
      acc     = s_valid && s_ready;
      step();
      if (acc) widx++;
      n++;
    end
    chk("gap_fire_seen", {31'd0, fire}, 32'd1);
    chk("gap_li0", {16'd0, layer_in[0]}, 32'h1111);
    chk("gap_li3", {16'd0, layer_in[3]}, 32'h4444);
    for (int i = 0; i < 4; i++) begin
      s_valid = (i % 2 == 0);
      s_data  = 16'hFFFF;
      step();
    end
    s_valid = 1'b0;
    layer_done(0, 16'h0001, 16'h0002);
    wait_idle();
    chk("gap_nacc", acc_cyc.size(), 32'd4);
    chk("gap_held", {16'd0, layer_in[2]}, 32'h3333);
    chk("gap_out1", {16'd0, emit_dat[1]}, 32'h0002);

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
